latch_bank_arbiter: RTL and testbench
=====================================

# latch_bank_arbiter

Round-robin arbiter and write sequencer for one shared WIDTH-bit level-sensitive storage word built from gated D latches (`latch_word`). Up to NREQ requesters post write requests. The block grants one at a time and drives the latch data and gate with a safe setup → gate-open → hold sequence, so latch data never changes while the gate is open. It sits between the requester logic and the latch storage, and exposes the stored word on `rdata`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: storage word width.
- `GATE_CYCLES`, default 1: cycles `latch_en` stays high per write, 1..15.

- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: level request per requester; held high until its `ack`.
- `wdata`  in  NREQ*WIDTH: requester i's data in bits `[i*WIDTH +: WIDTH]`.
- `ack`  out  NREQ: one-hot, one-cycle completion pulse to the granted requester.
- `busy`  out  1: high in every state except IDLE.
- `gnt_id`  out  clog2(NREQ): index of the current/last granted requester.
- `latch_d`  out  WIDTH: data driven to the latch word.
- `latch_en`  out  1: latch gate; the latch is transparent while high.
- `rdata`  out  WIDTH: Q outputs of the latch word.

## Operation
- FSM states: IDLE, SETUP, GATE, HOLD, ACK. All outputs are registered.
- **IDLE**
  - If any `req` is high, select the first requester at or after `(last + 1) mod NREQ`.
  - Register its `wdata` slice into `latch_d` and its index into `gnt_id`.
  - Go to SETUP. With no request, stay in IDLE.
- **SETUP**: `latch_en`=0 and `latch_d` stable; lasts 1 cycle; go to GATE.
- **GATE**
  - `latch_en`=1 for exactly GATE_CYCLES cycles, counted by a 4-bit counter.
  - `latch_d` is unchanged throughout. Then go to HOLD.
- **HOLD**: `latch_en`=0 and `latch_d` still held; lasts 1 cycle; go to ACK.
- **ACK**
  - `ack[gnt_id]`=1 for 1 cycle, and `last` is set to `gnt_id`.
  - Go to IDLE. IDLE arbitrates again on the following cycle.
- **Request drop mid-transaction**: once a request is granted, the write completes and `ack` is still pulsed, because the data was captured at grant. Requests are not re-sampled until IDLE.
- **Requester contract**: deassert `req` on the clock edge where `ack` is sampled high. A registered requester therefore never gets a double grant.
- **Reset** (asynchronous, immediate):
  - State IDLE; `ack`, `busy`, `latch_en`, `latch_d`, `gnt_id` all 0.
  - `last`=NREQ-1, so requester 0 has first priority.
- **Reset mid-write**
  - `latch_en` falls with `rst_n`; the write is abandoned and no `ack` is issued.
  - Latch contents have no reset. `rdata` keeps whatever was captured before the gate closed.
- **rdata**: follows `latch_d` while `latch_en`=1, and holds its value otherwise.

## Timing
- Grant sample edge = cycle 0.
  - SETUP in cycle 1.
  - GATE in cycles 2..1+G.
  - HOLD in cycle 2+G.
  - ACK in cycle 3+G.
- Latency from grant edge to `ack` high = 3+GATE_CYCLES cycles. Throughput = one write per 4+GATE_CYCLES cycles.
- `rdata` shows the new value from cycle 2, through the latch's combinational path.
- `latch_d` changes only at the IDLE→SETUP edge. It never changes in the same cycle `latch_en` rises or falls.
- Simultaneous requests: priority rotates strictly. Under continuous load, every requester is granted within NREQ transactions.

## Structure
- Shared package/include holds:
  - state encodings: IDLE=0, SETUP=1, GATE=2, HOLD=3, ACK=4 (3 bits);
  - default NREQ/WIDTH constants.
- Sub-module `latch_word`:
  - WIDTH instances of the existing gated D latch cell, plus NOT/AND/NOR gate primitives;
  - ports `d`, `en`, `q`.
- Arbiter, FSM and gate counter live in the top block.

## Test plan
- **Reset**: `rst_n`=0 → all outputs 0, `busy`=0. Release with `req`=0 → stays IDLE.
- **Single write**: `req`=4'b0010, `wdata[15:8]`=8'hA5, G=1.
  - `gnt_id`=1 and `latch_en` high exactly cycle 2.
  - `ack`=4'b0010 in cycle 4; `rdata`=8'hA5 afterwards.
- **Round-robin**: all four `req` held high, each dropped on its `ack` → grant order 0,1,2,3. Re-raising `req[0]` with `req[2]` → order resumes at 0 then 2.
- **Gate length**: G=3 → `latch_en` high cycles 2–4, `ack` in cycle 6, `latch_d` constant cycles 1–5.
- **Request drop**: `req[3]` dropped in SETUP → write completes and `ack[3]` pulses.
- **Reset mid-GATE**: `rst_n` low during GATE → `latch_en` 0 immediately, no `ack`, `rdata` keeps last written value.

Source files
------------

// File: rtl/latch_bank_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// latch_bank_arbiter_pkg
//   Shared definitions for the latch bank arbiter: the write-sequencer state
//   encoding and the default geometry constants.
// ----------------------------------------------------------------------------
package latch_bank_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_GATE  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    localparam int unsigned DEF_NREQ        = 4;
    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_GATE_CYCLES = 1;

endpackage

// File: rtl/latch_bank_arbiter_word.sv
// ----------------------------------------------------------------------------
// latch_word
//   WIDTH-bit level-sensitive storage word. Each bit is a gated D latch:
//   NOT/AND gates form the gated set/clear terms and the storage element is
//   transparent while en is high. There is no reset; contents persist.
//
//   d  : data in
//   en : gate, transparent while high
//   q  : latch outputs
// ----------------------------------------------------------------------------
module latch_word
    import latch_bank_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_dn;
        logic w_set;
        logic w_clr;
        logic r_bit;

        not u_inv (w_dn, d[i]);
        and u_set (w_set, d[i], en);
        and u_clr (w_clr, w_dn, en);

        always_latch begin
            if (w_set) begin
                r_bit <= 1'b1;
            end else if (w_clr) begin
                r_bit <= 1'b0;
            end
        end

        assign q[i] = r_bit;
    end

endmodule

// File: rtl/latch_bank_arbiter.sv
// ----------------------------------------------------------------------------
// latch_bank_arbiter
//   Round-robin arbiter and write sequencer for one shared latch word.
//   A granted write runs SETUP -> GATE (GATE_CYCLES) -> HOLD -> ACK so the
//   latch data is never changed while the gate is open.
//
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req      : level request per requester, held until ack
//   wdata    : requester i data in [i*WIDTH +: WIDTH]
//   ack      : one-hot one-cycle completion pulse
//   busy     : high in every state except IDLE
//   gnt_id   : index of current/last granted requester
//   latch_d  : data driven to the latch word
//   latch_en : latch gate
//   rdata    : latch word outputs
// ----------------------------------------------------------------------------
module latch_bank_arbiter
    import latch_bank_arbiter_pkg::*;
#(
    parameter int unsigned NREQ        = DEF_NREQ,
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           ack,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic [WIDTH-1:0]          latch_d,
    output logic                      latch_en,
    output logic [WIDTH-1:0]          rdata
);

    localparam int unsigned IW  = $clog2(NREQ);
    localparam logic [3:0]  GC4 = 4'(GATE_CYCLES);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    w_last_nxt;
    logic [IW-1:0]    r_gnt_id;
    logic [IW-1:0]    w_gnt_nxt;
    logic [WIDTH-1:0] r_latch_d;
    logic [WIDTH-1:0] w_latch_d_nxt;
    logic             r_latch_en;
    logic             r_busy;
    logic [NREQ-1:0]  r_ack;
    logic [NREQ-1:0]  w_ack_nxt;

    logic             w_hi_found;
    logic             w_lo_found;
    logic [IW-1:0]    w_hi;
    logic [IW-1:0]    w_lo;
    logic [IW-1:0]    w_sel;
    logic [WIDTH-1:0] w_sel_data;

    // Rotating priority: first requester above last wins, otherwise wrap to
    // the lowest requester (which may be last itself).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        w_sel_data = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (req[j] && (IW'(j) > r_last) && !w_hi_found) begin
                w_hi_found = 1'b1;
                w_hi       = IW'(j);
            end
            if (req[j] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo       = IW'(j);
            end
        end
        w_sel = w_hi_found ? w_hi : w_lo;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (IW'(j) == w_sel) begin
                w_sel_data = wdata[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt_id;
        w_latch_d_nxt = r_latch_d;
        w_last_nxt    = r_last;
        w_ack_nxt     = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt   = ST_SETUP;
                    w_gnt_nxt     = w_sel;
                    w_latch_d_nxt = w_sel_data;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_GATE;
                w_cnt_nxt   = 4'd1;
            end
            ST_GATE: begin
                if (r_cnt == GC4) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                w_last_nxt  = r_gnt_id;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        for (int unsigned j = 0; j < NREQ; j++) begin
            w_ack_nxt[j] = (w_state_nxt == ST_ACK) && (IW'(j) == w_gnt_nxt);
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last     <= IW'(NREQ - 1);
            r_gnt_id   <= '0;
            r_latch_d  <= '0;
            r_latch_en <= 1'b0;
            r_busy     <= 1'b0;
            r_ack      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_gnt_id   <= w_gnt_nxt;
            r_latch_d  <= w_latch_d_nxt;
            r_latch_en <= (w_state_nxt == ST_GATE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_ack      <= w_ack_nxt;
        end
    end

    latch_word #(
        .WIDTH(WIDTH)
    ) u_word (
        .d  (r_latch_d),
        .en (r_latch_en),
        .q  (rdata)
    );

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign gnt_id   = r_gnt_id;
    assign latch_d  = r_latch_d;
    assign latch_en = r_latch_en;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
module tb_latch_bank_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int          G     = 1;
    localparam int          G3    = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req, ack;
    logic [NREQ*WIDTH-1:0] wdata;
    logic                  busy, latch_en;
    logic [1:0]            gnt_id;
    logic [WIDTH-1:0]      latch_d, rdata;

    logic [NREQ-1:0]       req3, ack3;
    logic [NREQ*WIDTH-1:0] wdata3;
    logic                  busy3, latch_en3;
    logic [1:0]            gnt_id3;
    logic [WIDTH-1:0]      latch_d3, rdata3;

    latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GATE_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .ack(ack),
        .busy(busy), .gnt_id(gnt_id), .latch_d(latch_d), .latch_en(latch_en),
        .rdata(rdata)
    );

    latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GATE_CYCLES(G3)) dut_g3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .wdata(wdata3), .ack(ack3),
        .busy(busy3), .gnt_id(gnt_id3), .latch_d(latch_d3), .latch_en(latch_en3),
        .rdata(rdata3)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en  = 1'b0;
    bit rand_en = 1'b0;

    typedef struct {
        int unsigned      id;
        logic [WIDTH-1:0] data;
        int               ack_at;
    } exp_t;

    exp_t sb_q[$];

    // Transaction-level reference: a grant at edge t owns the bus until t+4+G,
    // gate open after edges t+1..t+G, ack after edge t+2+G.
    int unsigned      m_last = NREQ - 1;
    int               m_free = 0;
    bit               m_have = 1'b0;
    int               m_t    = 0;
    int unsigned      m_id   = 0;
    logic [WIDTH-1:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin : model
        exp_t        e;
        int unsigned idx;
        cyc++;
        if (!rst_n) begin
            m_last = NREQ - 1;
            m_free = 0;
            m_have = 1'b0;
        end else if (cyc >= m_free && req != '0) begin
            idx = 0;
            for (int unsigned k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (req[idx]) break;
            end
            m_id     = idx;
            m_data   = wdata[idx*WIDTH +: WIDTH];
            m_t      = cyc;
            m_free   = cyc + 4 + G;
            m_last   = idx;
            m_have   = 1'b1;
            e.id     = idx;
            e.data   = m_data;
            e.ack_at = cyc + 2 + G;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   in_txn;
        bit   gate_on;
        if (!rst_n) begin
            sb_q.delete();
        end else if (mon_en) begin
            in_txn  = m_have && (cyc >= m_t) && (cyc <= m_t + 2 + G);
            gate_on = m_have && (cyc >= m_t + 1) && (cyc <= m_t + G);
            chk("busy", 32'(busy), 32'(in_txn));
            chk("latch_en", 32'(latch_en), 32'(gate_on));
            if (in_txn) begin
                chk("latch_d", 32'(latch_d), 32'(m_data));
                chk("gnt_id", 32'(gnt_id), m_id);
            end
            if (ack != '0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_vec", 32'(ack), 32'(1 << e.id));
                    chk("ack_cycle", 32'(cyc), 32'(e.ack_at));
                    chk("ack_rdata", 32'(rdata), 32'(e.data));
                end
            end else if (sb_q.size() != 0 && cyc >= sb_q[0].ack_at) begin
                e = sb_q.pop_front();
                chk("ack_missing", 32'(ack), 32'(1 << e.id));
            end
        end
    end

    // Requester behaviour: drop on ack; with rand_en, randomly raise, withdraw
    // before grant, or drop after grant.
    always @(negedge clk) begin : driver
        bit outst;
        if (rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (rand_en) begin
                    outst = 1'b0;
                    foreach (sb_q[q]) if (sb_q[q].id == i) outst = 1'b1;
                    if (req[i]) begin
                        if (!outst && $urandom_range(0, 15) == 0) req[i] = 1'b0;
                        else if (outst && $urandom_range(0, 7) == 0) req[i] = 1'b0;
                    end else if (!outst && $urandom_range(0, 3) == 0) begin
                        wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                        req[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (req == '0 && sb_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: busy=%0b pending=%0d after %0d cycles", busy, sb_q.size(), budget);
        end
    endtask

    initial begin : stim
        bit found;
        rst_n  = 1'b0;
        req    = '0;
        wdata  = '0;
        req3   = '0;
        wdata3 = '0;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_latch_en", 32'(latch_en), 32'd0);
        chk("rst_latch_d", 32'(latch_d), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_g3_busy", 32'(busy3), 32'd0);
        chk("rst_g3_latch_en", 32'(latch_en3), 32'd0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Gate length 3 on the second instance
        wdata3[7:0] = 8'h3C;
        req3        = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("g3_latch_en", 32'(latch_en3), 32'(k >= 2 && k <= 4));
            chk("g3_ack", 32'(ack3), (k == 6) ? 32'd1 : 32'd0);
            chk("g3_busy", 32'(busy3), 32'(k <= 6));
            if (k <= 5) chk("g3_latch_d", 32'(latch_d3), 32'h3C);
            if (k == 6) begin
                chk("g3_rdata", 32'(rdata3), 32'h3C);
                req3 = '0;
            end
        end

        // Single write from requester 1
        wdata[15:8] = 8'hA5;
        req         = 4'b0010;
        wait_idle(40);
        chk("single_rdata", 32'(rdata), 32'hA5);

        // All four requesting, then 0 and 2 together
        wdata = 32'h44332211;
        req   = 4'b1111;
        wait_idle(80);
        wdata[7:0]   = 8'h10;
        wdata[23:16] = 8'h30;
        req          = 4'b0101;
        wait_idle(40);

        // Request 3 dropped during SETUP
        wdata[31:24] = 8'hC3;
        req          = 4'b1000;
        @(negedge clk);
        req[3] = 1'b0;
        wait_idle(40);
        chk("drop_rdata", 32'(rdata), 32'hC3);

        // Random load
        rand_en = 1'b1;
        repeat (3000) @(negedge clk);
        rand_en = 1'b0;
        wait_idle(400);

        // Reset during GATE
        wdata[23:16] = 8'h5A;
        req          = 4'b0100;
        found        = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (latch_en) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_bad++;
            $display("FAIL gate_wait_timeout: latch_en never rose");
        end
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("mid_rst_latch_en", 32'(latch_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_latch_d", 32'(latch_d), 32'd0);
        chk("mid_rst_rdata", 32'(rdata), 32'h5A);
        repeat (4) begin
            @(negedge clk);
            chk("in_rst_ack", 32'(ack), 32'd0);
            chk("in_rst_rdata", 32'(rdata), 32'h5A);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_rdata", 32'(rdata), 32'h5A);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
